// File: rtl/id_hazard_stall_ctrl_if.sv
// ID-stage hazard controller bus: hazard-detection inputs from the pipeline and
// the PC / IF/ID / ID/EX controls plus status and performance outputs.
interface id_hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             uses_rs_id;
  logic             uses_rt_id;
  logic             branch_id;
  logic             branch_taken_id;
  logic [4:0]       rd_ex;
  logic             reg_write_ex;
  logic             mem_read_ex;
  logic [4:0]       rd_ex_m;
  logic             mem_read_ex_m;
  logic             mem_stall;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       hz_state;
  logic             stall_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: supplies hazard inputs, consumes the controls.
  modport master (
    output id_valid, rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, branch_taken_id,
    output rd_ex, reg_write_ex, mem_read_ex, rd_ex_m, mem_read_ex_m, mem_stall,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, hz_state, stall_err,
    input  stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_valid, rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, branch_taken_id,
    input  rd_ex, reg_write_ex, mem_read_ex, rd_ex_m, mem_read_ex_m, mem_stall,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, hz_state, stall_err,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/id_hazard_stall_ctrl.sv
// ID-stage stall/flush controller. Detects hazards that ID forwarding cannot
// cover (load-use, branch operand in EX, branch operand loaded in MEM), drives
// PC / IF/ID / ID/EX controls, tracks the stall episode and a consecutive-stall
// watchdog. Define HAZARD_PERF_EN to build the stall/flush performance counters.
module id_hazard_stall_ctrl #(
  parameter int unsigned MAX_STALL = 2,
  parameter int unsigned CNT_W     = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  id_hazard_stall_ctrl_if.slave bus
);

  localparam logic [1:0] StRun      = 2'd0;
  localparam logic [1:0] StStallEx  = 2'd1;
  localparam logic [1:0] StStallMem = 2'd2;

  // Wide enough to hold the saturation value MAX_STALL+1.
  localparam int unsigned   RunW   = $clog2(MAX_STALL + 2);
  localparam logic [RunW-1:0] RunSat = RunW'(MAX_STALL + 1);
  localparam logic [RunW-1:0] RunLim = RunW'(MAX_STALL);

  logic            rs_ex, rt_ex, rs_m, rt_m;
  logic            hz_ex, hz_m, hazard, flush;
  logic [1:0]      state_q, state_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic            err_q, err_d;

  // Hazard detection and same-cycle pipeline controls.
  always_comb begin
    rs_ex  = bus.id_valid && bus.uses_rs_id && (bus.rs_id == bus.rd_ex) && (bus.rd_ex != 5'd0);
    rt_ex  = bus.id_valid && bus.uses_rt_id && (bus.rt_id == bus.rd_ex) && (bus.rd_ex != 5'd0);
    rs_m   = bus.id_valid && bus.uses_rs_id && (bus.rs_id == bus.rd_ex_m) &&
             (bus.rd_ex_m != 5'd0);
    rt_m   = bus.id_valid && bus.uses_rt_id && (bus.rt_id == bus.rd_ex_m) &&
             (bus.rd_ex_m != 5'd0);
    hz_ex  = (rs_ex || rt_ex) && (bus.mem_read_ex || (bus.branch_id && bus.reg_write_ex));
    hz_m   = bus.branch_id && bus.mem_read_ex_m && (rs_m || rt_m);
    hazard = hz_ex || hz_m;
    flush  = bus.id_valid && bus.branch_taken_id && !hazard && !bus.mem_stall;
  end

  assign bus.pc_write     = !(hazard || bus.mem_stall);
  assign bus.if_id_write  = !(hazard || bus.mem_stall);
  assign bus.id_ex_bubble = hazard && !bus.mem_stall;
  assign bus.if_id_flush  = flush;
  assign bus.hz_state     = state_q;
  assign bus.stall_err    = err_q;

  // Next state, consecutive-stall count and watchdog; everything holds while frozen.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    err_d     = err_q;
    if (!bus.mem_stall) begin
      if (hz_ex) begin
        state_d = StStallEx;
      end else if (hz_m) begin
        state_d = StStallMem;
      end else begin
        state_d = StRun;
      end
      if (hazard) begin
        run_cnt_d = (run_cnt_q == RunSat) ? RunSat : run_cnt_q + 1'b1;
        if (run_cnt_q >= RunLim) begin
          err_d = 1'b1;
        end
      end else begin
        run_cnt_d = '0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (bus.id_ex_bubble) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (flush)            flush_count_q  <= flush_count_q + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Directed bench for id_hazard_stall_ctrl: hand-computed expectations per step.
module tb_id_hazard_stall_ctrl;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  id_hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  id_hazard_stall_ctrl #(.MAX_STALL(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] perf(input int v);
`ifdef HAZARD_PERF_EN
    return 32'(v);
`else
    return 32'(v * 0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid        = 1'b1;
    bus.rs_id           = 5'd0;
    bus.rt_id           = 5'd0;
    bus.uses_rs_id      = 1'b0;
    bus.uses_rt_id      = 1'b0;
    bus.branch_id       = 1'b0;
    bus.branch_taken_id = 1'b0;
    bus.rd_ex           = 5'd0;
    bus.reg_write_ex    = 1'b0;
    bus.mem_read_ex     = 1'b0;
    bus.rd_ex_m         = 5'd0;
    bus.mem_read_ex_m   = 1'b0;
    bus.mem_stall       = 1'b0;
  endtask

  // ID reads rs=r, EX is a load to rd=r.
  task automatic load_use(input logic [4:0] r);
    idle();
    bus.rs_id = r; bus.uses_rs_id = 1'b1;
    bus.rd_ex = r; bus.mem_read_ex = 1'b1; bus.reg_write_ex = 1'b1;
  endtask

  initial begin
    // Reset
    idle();
    rst_n = 1'b0;
    step(); step();
    chk("rst_state", 32'(bus.hz_state), 0);
    chk("rst_err", 32'(bus.stall_err), 0);
    chk("rst_stallcnt", 32'(bus.stall_cycles), 0);
    chk("rst_flushcnt", 32'(bus.flush_count), 0);
    chk("rst_pcw", 32'(bus.pc_write), 1);
    rst_n = 1'b1;

    // Load-use: one stall cycle
    load_use(5'd5);
    #1;
    chk("lu_pcw", 32'(bus.pc_write), 0);
    chk("lu_ifidw", 32'(bus.if_id_write), 0);
    chk("lu_bubble", 32'(bus.id_ex_bubble), 1);
    chk("lu_flush", 32'(bus.if_id_flush), 0);
    step(); exp_stall++;
    chk("lu_state1", 32'(bus.hz_state), 1);
    idle(); bus.rs_id = 5'd5; bus.uses_rs_id = 1'b1; bus.rd_ex_m = 5'd5; bus.mem_read_ex_m = 1'b1;
    #1;
    chk("lu_pcw_after", 32'(bus.pc_write), 1);
    chk("lu_bubble_after", 32'(bus.id_ex_bubble), 0);
    step();
    chk("lu_state_run", 32'(bus.hz_state), 0);
    chk("lu_stallcnt", 32'(bus.stall_cycles), perf(exp_stall));

    // Branch on load: two stall cycles, EX then MEM
    load_use(5'd8); bus.branch_id = 1'b1;
    #1;
    chk("bl_bubble1", 32'(bus.id_ex_bubble), 1);
    step(); exp_stall++;
    chk("bl_state1", 32'(bus.hz_state), 1);
    idle(); bus.rs_id = 5'd8; bus.uses_rs_id = 1'b1; bus.branch_id = 1'b1;
    bus.rd_ex_m = 5'd8; bus.mem_read_ex_m = 1'b1;
    #1;
    chk("bl_bubble2", 32'(bus.id_ex_bubble), 1);
    chk("bl_pcw2", 32'(bus.pc_write), 0);
    step(); exp_stall++;
    chk("bl_state2", 32'(bus.hz_state), 2);
    idle(); bus.rs_id = 5'd8; bus.uses_rs_id = 1'b1; bus.branch_id = 1'b1;
    #1;
    chk("bl_pcw3", 32'(bus.pc_write), 1);
    step();
    chk("bl_state_run", 32'(bus.hz_state), 0);
    chk("bl_err", 32'(bus.stall_err), 0);
    chk("bl_stallcnt", 32'(bus.stall_cycles), perf(exp_stall));

    // Branch rt vs EX ALU write: one stall; then MEM non-load: none
    idle(); bus.rt_id = 5'd3; bus.uses_rt_id = 1'b1; bus.branch_id = 1'b1;
    bus.rd_ex = 5'd3; bus.reg_write_ex = 1'b1;
    #1;
    chk("ba_bubble", 32'(bus.id_ex_bubble), 1);
    step(); exp_stall++;
    chk("ba_state", 32'(bus.hz_state), 1);
    bus.rd_ex = 5'd0; bus.reg_write_ex = 1'b0; bus.rd_ex_m = 5'd3;
    #1;
    chk("ba_mem_bubble", 32'(bus.id_ex_bubble), 0);
    chk("ba_mem_pcw", 32'(bus.pc_write), 1);
    step();
    chk("ba_state_run", 32'(bus.hz_state), 0);
    // Non-branch reading an EX ALU result is forwarded, no stall
    idle(); bus.rt_id = 5'd3; bus.uses_rt_id = 1'b1; bus.rd_ex = 5'd3; bus.reg_write_ex = 1'b1;
    #1;
    chk("alu_fwd_bubble", 32'(bus.id_ex_bubble), 0);
    // Source not used by the instruction: no stall
    load_use(5'd9); bus.uses_rs_id = 1'b0;
    #1;
    chk("unused_src", 32'(bus.id_ex_bubble), 0);

    // Taken branch, no hazard: flush one cycle
    idle(); bus.branch_id = 1'b1; bus.branch_taken_id = 1'b1;
    bus.rs_id = 5'd1; bus.uses_rs_id = 1'b1; bus.rd_ex = 5'd2; bus.reg_write_ex = 1'b1;
    #1;
    chk("tk_flush", 32'(bus.if_id_flush), 1);
    chk("tk_pcw", 32'(bus.pc_write), 1);
    step(); exp_flush++;
    chk("tk_state", 32'(bus.hz_state), 0);
    chk("tk_flushcnt", 32'(bus.flush_count), perf(exp_flush));
    // id_valid=0 suppresses hazard and flush
    load_use(5'd4); bus.branch_id = 1'b1; bus.branch_taken_id = 1'b1; bus.id_valid = 1'b0;
    #1;
    chk("inv_bubble", 32'(bus.id_ex_bubble), 0);
    chk("inv_flush", 32'(bus.if_id_flush), 0);
    step();

    // Enter STALL_EX, then freeze with mem_stall: state held, no flush/bubble
    load_use(5'd6);
    step(); exp_stall++;
    chk("ms_state_pre", 32'(bus.hz_state), 1);
    idle(); bus.mem_stall = 1'b1; bus.branch_id = 1'b1; bus.branch_taken_id = 1'b1;
    #1;
    chk("ms_pcw", 32'(bus.pc_write), 0);
    chk("ms_ifidw", 32'(bus.if_id_write), 0);
    chk("ms_flush", 32'(bus.if_id_flush), 0);
    chk("ms_bubble", 32'(bus.id_ex_bubble), 0);
    step();
    chk("ms_state_hold", 32'(bus.hz_state), 1);
    load_use(5'd6); bus.mem_stall = 1'b1;
    #1;
    chk("ms_hz_bubble", 32'(bus.id_ex_bubble), 0);
    step();
    chk("ms_state_hold2", 32'(bus.hz_state), 1);
    chk("ms_flushcnt", 32'(bus.flush_count), perf(exp_flush));
    chk("ms_stallcnt", 32'(bus.stall_cycles), perf(exp_stall));
    idle();
    step();
    chk("ms_state_run", 32'(bus.hz_state), 0);

    // Watchdog: 3 consecutive hazard cycles with MAX_STALL=2
    load_use(5'd7);
    step(); exp_stall++;
    chk("wd_err1", 32'(bus.stall_err), 0);
    step(); exp_stall++;
    chk("wd_err2", 32'(bus.stall_err), 0);
    step(); exp_stall++;
    chk("wd_err3", 32'(bus.stall_err), 1);
    idle();
    step();
    chk("wd_err_sticky", 32'(bus.stall_err), 1);
    chk("wd_stallcnt", 32'(bus.stall_cycles), perf(exp_stall));
    rst_n = 1'b0;
    step();
    chk("wd_err_rst", 32'(bus.stall_err), 0);
    rst_n = 1'b1;
    exp_stall = 0; exp_flush = 0;

    // Register 0 never hazards
    load_use(5'd0);
    #1;
    chk("r0_bubble", 32'(bus.id_ex_bubble), 0);
    chk("r0_pcw", 32'(bus.pc_write), 1);
    step();
    chk("r0_state", 32'(bus.hz_state), 0);

    // Reset mid-STALL_EX abandons the episode
    load_use(5'd10);
    step(); exp_stall++;
    chk("rm_state_pre", 32'(bus.hz_state), 1);
    step(); exp_stall++;
    chk("rm_stallcnt_pre", 32'(bus.stall_cycles), perf(exp_stall));
    rst_n = 1'b0;
    #1;
    chk("rm_bubble_in_rst", 32'(bus.id_ex_bubble), 1);
    step();
    chk("rm_state", 32'(bus.hz_state), 0);
    chk("rm_stallcnt", 32'(bus.stall_cycles), 0);
    chk("rm_flushcnt", 32'(bus.flush_count), 0);
    chk("rm_err", 32'(bus.stall_err), 0);
    rst_n = 1'b1;
    // Fresh episode after reset: two stalls must not trip the watchdog
    step();
    step();
    chk("rm_err_after", 32'(bus.stall_err), 0);
    idle();
    step();
    chk("rm_state_run", 32'(bus.hz_state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
